mem_mailbox: RTL and testbench

MEM_MAILBOX -- requirements
Module: mem_mailbox

---
 rtl/mem_mailbox.sv | 156 +++++++++++++++
 tb/tb_mem_mailbox.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_mailbox.sv
// mem_mailbox
//
// This module is a test-harness mailbox that sits on a core's data bus. It
// provides a word-addressed data RAM and watches every store. A store of an
// agreed value to an agreed address ends the run as PASS. An agreed
// non-terminal store sets the sticky pass_r flag. Stores to the scratch
// address are always legal. Any other store ends the run as FAIL and
// captures the offending address and data.
//
// Optional feature:
//   MEM_MAILBOX_TIMEOUT_EN  When this is defined, a run that stays in RUN for
//                           TIMEOUT_CYCLES cycles ends in TIMEOUT. When it is
//                           undefined, there is no timeout logic and
//                           timeout is held at 0.
//
// Ports:
//   clk          single clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   MemWrite     store strobe; one write for each cycle it is asserted
//   DataAdr      byte address of the load or store
//   WriteData    store data
//   ReadData     combinational read of the RAM word that DataAdr selects
//   done         high in PASS, FAIL or TIMEOUT
//   pass_a       high in PASS (terminal pass store seen)
//   pass_r       sticky flag for the non-terminal pass store
//   fail         high in FAIL
//   timeout      high in TIMEOUT
//   fail_addr    DataAdr of the store that caused FAIL
//   fail_data    WriteData of the store that caused FAIL
//   cycle_count  number of cycles spent in RUN (saturates at 16'hFFFF)
//   write_count  number of stores accepted in RUN (saturates at 16'hFFFF)
//
// State table:
//   state    | meaning
//   RUN      | monitoring stores and counting cycles
//   PASS     | terminal: terminal pass store observed
//   FAIL     | terminal: illegal store observed and captured
//   TIMEOUT  | terminal: RUN cycle limit reached (only with timeout enabled)

module mem_mailbox #(
    parameter int          MEM_WORDS      = 64,
    parameter int          TIMEOUT_CYCLES = 100,
    parameter logic [31:0] PASS_ADDR_A    = 32'd44,
    parameter logic [31:0] PASS_DATA_A    = 32'd25,
    parameter logic [31:0] PASS_ADDR_R    = 32'd100,
    parameter logic [31:0] PASS_DATA_R    = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass_a,
    output logic        pass_r,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_data,
    output logic [15:0] cycle_count,
    output logic [15:0] write_count
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_t;

    state_t       state;
    logic [31:0]  mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [15:0]  cycle_inc;
    logic [15:0]  write_inc;
    logic         hit_a;
    logic         hit_r;
    logic         hit_scratch;

    assign idx = DataAdr[AW+1:2];

    // RAM write is independent of mailbox state. Reset blocks the write so
    // that a store in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset && MemWrite) begin
            mem[idx] <= WriteData;
        end
    end

    assign ReadData = mem[idx];

    assign cycle_inc = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
    assign write_inc = (write_count == 16'hFFFF) ? write_count : write_count + 16'd1;

    assign hit_a       = (DataAdr == PASS_ADDR_A) && (WriteData == PASS_DATA_A);
    assign hit_r       = (DataAdr == PASS_ADDR_R) && (WriteData == PASS_DATA_R);
    assign hit_scratch = (DataAdr == SCRATCH_ADDR);

`ifdef MEM_MAILBOX_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            done        <= 1'b0;
            pass_a      <= 1'b0;
            pass_r      <= 1'b0;
            fail        <= 1'b0;
`ifdef MEM_MAILBOX_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
            fail_addr   <= 32'd0;
            fail_data   <= 32'd0;
            cycle_count <= 16'd0;
            write_count <= 16'd0;
        end else begin
            case (state)
                RUN: begin
                    cycle_count <= cycle_inc;
                    if (MemWrite) begin
                        // A store outranks the timeout check in the same cycle.
                        write_count <= write_inc;
                        if (hit_a) begin
                            state  <= PASS;
                            done   <= 1'b1;
                            pass_a <= 1'b1;
                        end else if (hit_r) begin
                            pass_r <= 1'b1;
                        end else if (!hit_scratch) begin
                            state     <= FAIL;
                            done      <= 1'b1;
                            fail      <= 1'b1;
                            fail_addr <= DataAdr;
                            fail_data <= WriteData;
                        end
                    end
`ifdef MEM_MAILBOX_TIMEOUT_EN
                    // The check uses >= because a store in the limit cycle
                    // lets the count pass the limit.
                    else if (cycle_inc >= TIMEOUT_LIM) begin
                        state   <= TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
`endif
                end
                default: begin
                    // Terminal states keep all status until the next reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_mailbox.sv
module tb_mem_mailbox;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        done, pass_a, pass_r, fail, timeout;
    logic [31:0] fail_addr, fail_data;
    logic [15:0] cycle_count, write_count;

    int tests = 0;
    int errors = 0;

    mem_mailbox dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .done(done),
        .pass_a(pass_a), .pass_r(pass_r), .fail(fail), .timeout(timeout),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .cycle_count(cycle_count), .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic        pa;
        logic        pr;
        logic        fl;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        idle(1);
        MemWrite  = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWrite = 1'b0;
        DataAdr  = a;
        #1;
        chk(name, ReadData, exp);
    endtask

    initial begin
        vecs[0] = '{32'd96,         32'd5,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd44,         32'd25, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'd100,        32'd7,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'd100,        32'd8,  1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'd44,         32'd24, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h8000_002C,  32'd25, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'd45,         32'd25, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'd8,          32'd1,  1'b0, 1'b0, 1'b1};

        // reset state
        do_reset();
        chk("rst_done", 32'(done), 0);
        chk("rst_status", {27'd0, pass_a, pass_r, fail, timeout, 1'b0}, 0);
        chk("rst_counts", {cycle_count, write_count}, 0);

        // single-store table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            store(vecs[i].adr, vecs[i].data);
            chk($sformatf("v%0d_pass_a", i), 32'(pass_a), 32'(vecs[i].pa));
            chk($sformatf("v%0d_pass_r", i), 32'(pass_r), 32'(vecs[i].pr));
            chk($sformatf("v%0d_fail", i), 32'(fail), 32'(vecs[i].fl));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].pa | vecs[i].fl));
            chk($sformatf("v%0d_wcnt", i), 32'(write_count), 1);
            chk($sformatf("v%0d_ccnt", i), 32'(cycle_count), 1);
            if (vecs[i].fl) begin
                chk($sformatf("v%0d_fail_addr", i), fail_addr, vecs[i].adr);
                chk($sformatf("v%0d_fail_data", i), fail_data, vecs[i].data);
            end
        end

        // scratch then terminal pass; terminal state ignores later stores
        do_reset();
        store(32'd96, 32'd5);
        store(32'd44, 32'd25);
        chk("pa_fail", 32'(fail), 0);
        chk("pa_done", 32'(done), 1);
        chk("pa_pass_a", 32'(pass_a), 1);
        chk("pa_wcnt", 32'(write_count), 2);
        read_chk("pa_ram11", 32'd44, 32'd25);
        idle(3);
        chk("pa_ccnt_frozen", 32'(cycle_count), 2);
        store(32'd8, 32'd3);
        chk("pa_term_wcnt", 32'(write_count), 2);
        chk("pa_term_fail", 32'(fail), 0);
        read_chk("pa_term_ram", 32'd8, 32'd3);

        // sticky pass_r
        do_reset();
        store(32'd100, 32'd7);
        store(32'd96, 32'd1);
        chk("pr_pass_r", 32'(pass_r), 1);
        chk("pr_done", 32'(done), 0);
        store(32'd44, 32'd25);
        chk("pr_pass_a", 32'(pass_a), 1);
        chk("pr_pass_r_kept", 32'(pass_r), 1);

        // fail capture is final
        do_reset();
        store(32'd44, 32'd24);
        chk("fl_fail", 32'(fail), 1);
        chk("fl_addr", fail_addr, 32'd44);
        chk("fl_data", fail_data, 32'd24);
        store(32'd44, 32'd25);
        chk("fl_no_pass", 32'(pass_a), 0);
        chk("fl_data_kept", fail_data, 32'd24);
        chk("fl_wcnt_frozen", 32'(write_count), 1);

        // RAM is kept through reset, and a store in a reset cycle is dropped
        do_reset();
        store(32'd8, 32'hDEAD_BEEF);
        MemWrite  = 1'b1;
        DataAdr   = 32'd8;
        WriteData = 32'd0;
        reset     = 1'b1;
        idle(2);
        reset     = 1'b0;
        MemWrite  = 1'b0;
        read_chk("ram_retained", 32'd8, 32'hDEAD_BEEF);
        chk("ram_rst_status", {27'd0, done, pass_a, pass_r, fail, timeout}, 0);
        chk("ram_rst_fail_addr", fail_addr, 0);

        // timeout, and a store that outranks it
        do_reset();
`ifdef MEM_MAILBOX_TIMEOUT_EN
        idle(99);
        chk("to_early", 32'(timeout), 0);
        idle(1);
        chk("to_timeout", 32'(timeout), 1);
        chk("to_done", 32'(done), 1);
        chk("to_ccnt", 32'(cycle_count), 100);
`else
        idle(200);
        chk("nto_done", 32'(done), 0);
        chk("nto_timeout", 32'(timeout), 0);
        chk("nto_ccnt", 32'(cycle_count), 200);
`endif
        do_reset();
        idle(99);
        store(32'd44, 32'd24);
        chk("prio_fail", 32'(fail), 1);
        chk("prio_timeout", 32'(timeout), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
